td4_sequencer: RTL
==================

TD4_SEQUENCER -- requirements
Module: td4_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 0: execute one instruction every TICK_DIV+1 clk cycles in RUN.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports run (in, 1, level request to execute), step (in, 1, single-step pulse) and load_en (in, 1, memory-load mode request).
REQ-005 SHALL have ports load_addr (in, 4), load_opcode (in, 4), load_imm (in, 4) and load_we (in, 1) as the external program-load port.
REQ-006 SHALL have ports in_port (in, 4, IN source) and out_port (out, 4, registered OUT value).
REQ-007 SHALL have ports mem_addr (out, 4), mem_we (out, 1), mem_wopcode (out, 4), mem_wimm (out, 4), mem_opcode (in, 4) and mem_imm (in, 4) for the program memory, whose read is combinational.
REQ-008 SHALL have ports pc (out, 4), carry (out, 1) and state (out, 2; HALT=0, RUN=1, LOAD=2) for observation.

Function
REQ-009 SHALL implement FSM HALT/RUN/LOAD; input priority load_en > run > step.
REQ-010 HALT: load_en -> LOAD; else run -> RUN; else stay.
REQ-011 RUN: load_en -> LOAD; else !run -> HALT; no instruction executes on the transition edge.
REQ-012 LOAD: !load_en -> HALT with pc cleared to 0; A, B, carry and out_port unchanged.
REQ-013 In LOAD, mem_addr=load_addr, mem_we=load_we, mem_wopcode=load_opcode, mem_wimm=load_imm; in other states mem_addr=pc and mem_we=0.
REQ-014 Tick: prescaler counts 0..TICK_DIV; cleared on entry to RUN; an instruction executes on the edge where the count equals TICK_DIV; with TICK_DIV=0, one instruction per cycle.
REQ-015 Execute the instruction at mem_opcode/mem_imm for pc: 0000 A=A+Im; 0101 B=B+Im; 0011 A=Im; 0111 B=Im; 0001 A=B; 0100 B=A; 0010 A=in_port; 0110 B=in_port; 1001 out=B; 1011 out=Im; 1111 pc=Im; 1110 if carry==0 then pc=Im.
REQ-016 Arithmetic is 4-bit modulo 16; ADD loads carry with bit 4 of the sum; every other opcode, including a taken or untaken JNC, clears carry.
REQ-017 JNC tests the carry produced by the previous executed instruction.
REQ-018 pc increments modulo 16 (15 -> 0) unless a jump is taken.
REQ-019 Undefined opcodes are NOPs: pc increments and carry clears.
REQ-020 Internal registers A and B are 4 bits wide and are not outputs.

Reset
REQ-021 rst SHALL force state=HALT, pc=0, A=0, B=0, carry=0, out_port=0 and prescaler=0 immediately, including mid-RUN or mid-LOAD.
REQ-022 During reset mem_we SHALL be 0 and mem_addr SHALL be 0.

Configuration
REQ-023 Macro TD4_STEP_EN: when defined, a rising edge of step detected in HALT (step high, previous sample low) SHALL execute exactly one instruction and remain in HALT.
REQ-024 When TD4_STEP_EN is undefined, step SHALL be ignored and no edge-detect register SHALL exist.

Structure
REQ-025 A shared package td4_pkg SHALL hold the opcode constants, the state encoding and the 4-bit data-width constant.
REQ-026 Opcode decode and execute SHALL live in one sub-module, td4_alu_exec, which is combinational: inputs are the instruction, A, B, carry, pc and in_port; outputs are the next values.

Verification
REQ-027 Load program {0:0011/0xE, 1:0000/0x3, 2:1110/0x0, 3:1011/0x5, 4:1111/0x4}, release load_en, then run=1: A=0xE, then A=0x1 with carry=1, JNC not taken, out_port=0x5, pc then loops at 4.
REQ-028 Program {0:0011/0x1, 1:1110/0x3, 3:1011/0xA}: JNC at pc=1 is taken (carry=0), pc goes 1 -> 3 and out_port=0xA.
REQ-029 in_port=0x9 with program {0:0110/0, 1:1001/0}: B=0x9 and out_port=0x9 after 2 ticks.
REQ-030 With TICK_DIV=3, each pc change is spaced exactly 4 clk cycles; asserting rst mid-run gives pc=0, out_port=0 and state=HALT in the same cycle.
REQ-031 load_en raised in RUN: the next cycle has state=LOAD, mem_addr follows load_addr and pc does not change; after load_en falls, state=HALT and pc=0.
REQ-032 With TD4_STEP_EN: step held high for 5 cycles in HALT advances pc by exactly 1; without TD4_STEP_EN, pc stays unchanged.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 sequencer: data width, FSM state encoding
// and the 4-bit opcode map.
package td4_pkg;
  localparam int DW = 4;

  typedef logic [DW-1:0] word_t;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;
endpackage

// File: rtl/td4_sequencer_if.sv
// Program-memory bus between the sequencer (master) and the instruction store (slave).
interface td4_sequencer_if;
  import td4_pkg::*;

  // No handshake: a write happens on the clock edge where mem_we is high, and
  // mem_opcode/mem_imm are a combinational read of mem_addr in the same cycle.
  word_t mem_addr;
  logic  mem_we;
  word_t mem_wopcode;
  word_t mem_wimm;
  word_t mem_opcode;
  word_t mem_imm;

  modport master (
    output mem_addr, mem_we, mem_wopcode, mem_wimm,
    input  mem_opcode, mem_imm
  );

  modport slave (
    input  mem_addr, mem_we, mem_wopcode, mem_wimm,
    output mem_opcode, mem_imm
  );
endinterface

// File: rtl/td4_alu_exec.sv
// Combinational decode/execute of one TD4 instruction: produces the next
// register values; the caller decides whether to commit them.
module td4_alu_exec
  import td4_pkg::*;
(
  input  word_t opcode,
  input  word_t imm,
  input  word_t a,
  input  word_t b,
  input  logic  carry,
  input  word_t pc,
  input  word_t in_port,
  output word_t a_next,
  output word_t b_next,
  output logic  carry_next,
  output word_t pc_next,
  output word_t out_next,
  output logic  out_we
);
  logic [DW:0] sum_a;
  logic [DW:0] sum_b;

  assign sum_a = {1'b0, a} + {1'b0, imm};
  assign sum_b = {1'b0, b} + {1'b0, imm};

  always_comb begin
    a_next     = a;
    b_next     = b;
    carry_next = 1'b0;
    pc_next    = pc + 4'd1;
    out_next   = b;
    out_we     = 1'b0;
    unique case (opcode)
      OP_ADD_A:  {carry_next, a_next} = sum_a;
      OP_ADD_B:  {carry_next, b_next} = sum_b;
      OP_MOV_A:  a_next = imm;
      OP_MOV_B:  b_next = imm;
      OP_MOV_AB: a_next = b;
      OP_MOV_BA: b_next = a;
      OP_IN_A:   a_next = in_port;
      OP_IN_B:   b_next = in_port;
      OP_OUT_B:  out_we = 1'b1;
      OP_OUT_IM: begin
        out_next = imm;
        out_we   = 1'b1;
      end
      OP_JMP:    pc_next = imm;
      // carry here is the flag left by the previous executed instruction
      OP_JNC:    if (!carry) pc_next = imm;
      default:   ;
    endcase
  end
endmodule

// File: rtl/td4_sequencer.sv
// TD4 sequencer: HALT/RUN/LOAD control, tick prescaler and architectural state.
// Optional build macro TD4_STEP_EN enables single-stepping from HALT on step rising edges.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int TICK_DIV = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    step,
  input  logic                    load_en,
  input  word_t                   load_addr,
  input  word_t                   load_opcode,
  input  word_t                   load_imm,
  input  logic                    load_we,
  input  word_t                   in_port,
  output word_t                   out_port,
  td4_sequencer_if.master         mem,
  output word_t                   pc,
  output logic                    carry,
  output logic [1:0]              state
);
  localparam int PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  state_t        state_q, state_n;
  logic [PW-1:0] presc_q;
  word_t         pc_q, a_q, b_q, out_q;
  logic          carry_q;
  logic          tick, exec, enter_run, leave_load;

  word_t a_n, b_n, pc_n, out_n;
  logic  carry_n, out_we;

`ifdef TD4_STEP_EN
  logic step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end
`else
  logic unused_step;
  assign unused_step = step;
`endif

  assign tick = (presc_q == PW'(TICK_DIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_HALT;
    else     state_q <= state_n;
  end

  // Priority load_en > run > step; leaving RUN never executes on that edge.
  always_comb begin
    state_n    = state_q;
    enter_run  = 1'b0;
    leave_load = 1'b0;
    exec       = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (load_en) state_n = ST_LOAD;
        else if (run) begin
          state_n   = ST_RUN;
          enter_run = 1'b1;
        end
`ifdef TD4_STEP_EN
        else if (step && !step_q) exec = 1'b1;
`endif
      end
      ST_RUN: begin
        if (load_en)   state_n = ST_LOAD;
        else if (!run) state_n = ST_HALT;
        else           exec    = tick;
      end
      ST_LOAD: begin
        if (!load_en) begin
          state_n    = ST_HALT;
          leave_load = 1'b1;
        end
      end
      default: state_n = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    presc_q <= '0;
    else if (enter_run)         presc_q <= '0;
    else if (state_q == ST_RUN) presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  td4_alu_exec u_alu (
    .opcode     (mem.mem_opcode),
    .imm        (mem.mem_imm),
    .a          (a_q),
    .b          (b_q),
    .carry      (carry_q),
    .pc         (pc_q),
    .in_port    (in_port),
    .a_next     (a_n),
    .b_next     (b_n),
    .carry_next (carry_n),
    .pc_next    (pc_n),
    .out_next   (out_n),
    .out_we     (out_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
    end else if (leave_load) begin
      pc_q <= '0;
    end else if (exec) begin
      pc_q    <= pc_n;
      a_q     <= a_n;
      b_q     <= b_n;
      carry_q <= carry_n;
      if (out_we) out_q <= out_n;
    end
  end

  // Reset leaves state=HALT and pc=0, so the bus reads address 0 with no write.
  always_comb begin
    mem.mem_addr    = pc_q;
    mem.mem_we      = 1'b0;
    mem.mem_wopcode = '0;
    mem.mem_wimm    = '0;
    if (state_q == ST_LOAD) begin
      mem.mem_addr    = load_addr;
      mem.mem_we      = load_we;
      mem.mem_wopcode = load_opcode;
      mem.mem_wimm    = load_imm;
    end
  end

  assign out_port = out_q;
  assign pc       = pc_q;
  assign carry    = carry_q;
  assign state    = state_q;
endmodule
